// File: rtl/ping_pong_ctrl_n.sv
// North ping-pong buffer controller: fills one bank from a valid/ready stream
// while streaming the other, full bank to the systolic array slice by slice.
//
// Read FSM states:
//   state  | meaning
//   R_IDLE | waiting for bank_full[rd_bank]
//   R_RUN  | issuing one read per sa_ready cycle from rd_bank
module ping_pong_ctrl_n #(
    parameter int ADDR_WIDTH    = 8,
    parameter int TOTAL_DEPTH   = 12,
    parameter int TOTAL_MODULES = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             sa_ready,
    output logic [$clog2(TOTAL_MODULES)-1:0] slicing_idx,
    output logic                             out_valid,
    output logic                             out_bank,
    output logic                             frame_done,
    output logic [1:0]                       bank_full,
    output logic                             bank0_ena,
    output logic                             bank1_ena,
    output logic                             bank0_wea,
    output logic                             bank1_wea,
    output logic [ADDR_WIDTH-1:0]            bank0_addra,
    output logic [ADDR_WIDTH-1:0]            bank1_addra
);

    localparam int SW = $clog2(TOTAL_MODULES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(TOTAL_DEPTH - 1);
    localparam logic [SW-1:0]         SLICE_LAST = SW'(TOTAL_MODULES - 1);

    typedef enum logic {
        R_IDLE,
        R_RUN
    } r_state_t;

    r_state_t              r_state;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [SW-1:0]         slice_cnt;

    logic       wr_fire;
    logic       rd_issue;
    logic       wr_last;
    logic       rd_last;
    logic [1:0] full_set;
    logic [1:0] full_clr;

    assign in_ready = rst_n & ~bank_full[wr_bank];
    assign wr_fire  = in_valid & in_ready;
    // Issues are suppressed during reset so the bank sees no stray read.
    assign rd_issue = rst_n & (r_state == R_RUN) & sa_ready;
    assign wr_last  = wr_fire & (wr_addr == ADDR_LAST);
    assign rd_last  = rd_issue & (rd_addr == ADDR_LAST) & (slice_cnt == SLICE_LAST);

    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        if (wr_last) full_set[wr_bank] = 1'b1;
        if (rd_last) full_clr[rd_bank] = 1'b1;
    end

    // The write bank is never full and the read bank always is, so at most
    // one side drives each bank in any cycle.
    always_comb begin
        bank0_ena   = 1'b0;
        bank0_wea   = 1'b0;
        bank0_addra = '0;
        bank1_ena   = 1'b0;
        bank1_wea   = 1'b0;
        bank1_addra = '0;
        if (wr_fire) begin
            if (wr_bank == 1'b0) begin
                bank0_ena   = 1'b1;
                bank0_wea   = 1'b1;
                bank0_addra = wr_addr;
            end else begin
                bank1_ena   = 1'b1;
                bank1_wea   = 1'b1;
                bank1_addra = wr_addr;
            end
        end
        if (rd_issue) begin
            if (rd_bank == 1'b0) begin
                bank0_ena   = 1'b1;
                bank0_addra = rd_addr;
            end else begin
                bank1_ena   = 1'b1;
                bank1_addra = rd_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank     <= 1'b0;
            wr_addr     <= '0;
            bank_full   <= 2'b00;
        end else begin
            bank_full <= (bank_full | full_set) & ~full_clr;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_addr <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= R_IDLE;
            rd_bank     <= 1'b0;
            rd_addr     <= '0;
            slice_cnt   <= '0;
            out_valid   <= 1'b0;
            slicing_idx <= '0;
            out_bank    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            out_valid  <= rd_issue;
            frame_done <= rd_last;
            if (rd_issue) begin
                slicing_idx <= slice_cnt;
                out_bank    <= rd_bank;
            end
            case (r_state)
                R_IDLE: begin
                    if (bank_full[rd_bank]) r_state <= R_RUN;
                end
                R_RUN: begin
                    if (rd_issue) begin
                        if (rd_last) begin
                            slice_cnt <= '0;
                            rd_addr   <= '0;
                            rd_bank   <= ~rd_bank;
                            r_state   <= R_IDLE;
                        end else if (slice_cnt == SLICE_LAST) begin
                            slice_cnt <= '0;
                            rd_addr   <= rd_addr + ADDR_WIDTH'(1);
                        end else begin
                            slice_cnt <= slice_cnt + SW'(1);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ping_pong_ctrl_n.sv
// Randomized bench for ping_pong_ctrl_n against a transaction-level model
// tracking fill counts per bank and a flat issue index per frame.
module tb_ping_pong_ctrl_n;

    localparam int AW    = 8;
    localparam int DEPTH = 12;
    localparam int MODS  = 4;
    localparam int SW    = $clog2(MODS);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          sa_ready;
    logic [SW-1:0] slicing_idx;
    logic          out_valid;
    logic          out_bank;
    logic          frame_done;
    logic [1:0]    bank_full;
    logic          bank0_ena, bank1_ena, bank0_wea, bank1_wea;
    logic [AW-1:0] bank0_addra, bank1_addra;

    always #5 clk = ~clk;

    ping_pong_ctrl_n #(
        .ADDR_WIDTH   (AW),
        .TOTAL_DEPTH  (DEPTH),
        .TOTAL_MODULES(MODS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sa_ready   (sa_ready),
        .slicing_idx(slicing_idx),
        .out_valid  (out_valid),
        .out_bank   (out_bank),
        .frame_done (frame_done),
        .bank_full  (bank_full),
        .bank0_ena  (bank0_ena),
        .bank1_ena  (bank1_ena),
        .bank0_wea  (bank0_wea),
        .bank1_wea  (bank1_wea),
        .bank0_addra(bank0_addra),
        .bank1_addra(bank1_addra)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // model: words in current fill, flat issue index within the frame being read
    bit       m_ok = 0;
    bit [1:0] m_full;
    bit       m_wb, m_rb, m_run;
    int       m_wcnt, m_idx;
    bit       e_ov, e_fd, e_ob;
    int       e_slice;
    int       ov_cnt, fd_cnt;

    task automatic model_reset();
        m_full = 2'b00; m_wb = 0; m_rb = 0; m_run = 0;
        m_wcnt = 0; m_idx = 0;
        e_ov = 0; e_fd = 0; e_ob = 0; e_slice = 0;
        m_ok = 1;
    endtask

    task automatic model_update(input bit rst, input bit iv, input bit sr);
        bit       wr, iss;
        bit [1:0] nf;
        if (!rst) begin
            model_reset();
            return;
        end
        wr  = iv && !m_full[m_wb];
        iss = m_run && sr;
        nf  = m_full;
        e_ov = iss;
        e_fd = 0;
        if (iss) begin
            e_slice = m_idx % MODS;
            e_ob    = m_rb;
        end
        if (wr) begin
            m_wcnt++;
            if (m_wcnt == DEPTH) begin
                nf[m_wb] = 1;
                m_wb     = !m_wb;
                m_wcnt   = 0;
            end
        end
        if (iss) begin
            m_idx++;
            if (m_idx == DEPTH * MODS) begin
                nf[m_rb] = 0;
                m_rb     = !m_rb;
                m_idx    = 0;
                m_run    = 0;
                e_fd     = 1;
            end
        end else if (!m_run) begin
            m_run = m_full[m_rb];
        end
        m_full = nf;
    endtask

    task automatic check_regs();
        if (!m_ok) return;
        check_val("out_valid", out_valid, e_ov);
        check_val("frame_done", frame_done, e_fd);
        check_val("bank_full", bank_full, m_full);
        check_val("slicing_idx", slicing_idx, e_slice);
        check_val("out_bank", out_bank, e_ob);
        if (out_valid === 1'b1) ov_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic check_comb(input bit rst, input bit iv, input bit sr);
        bit ir, wr, iss;
        bit ena[2], wea[2];
        int adr[2];
        ena[0] = 0; ena[1] = 0; wea[0] = 0; wea[1] = 0; adr[0] = 0; adr[1] = 0;
        ir  = rst && !m_full[m_wb];
        wr  = iv && ir;
        iss = rst && m_run && sr;
        if (wr) begin
            ena[m_wb] = 1; wea[m_wb] = 1; adr[m_wb] = m_wcnt;
        end
        if (iss) begin
            ena[m_rb] = 1; adr[m_rb] = m_idx / MODS;
        end
        check_val("in_ready", in_ready, ir);
        check_val("bank0_ena", bank0_ena, ena[0]);
        check_val("bank1_ena", bank1_ena, ena[1]);
        check_val("bank0_wea", bank0_wea, wea[0]);
        check_val("bank1_wea", bank1_wea, wea[1]);
        check_val("bank0_addra", bank0_addra, adr[0]);
        check_val("bank1_addra", bank1_addra, adr[1]);
    endtask

    task automatic step(input bit rst, input bit iv, input bit sr);
        @(negedge clk);
        check_regs();
        rst_n    = rst;
        in_valid = iv;
        sa_ready = sr;
        #1;
        if (m_ok) check_comb(rst, iv, sr);
        @(posedge clk);
        model_update(rst, iv, sr);
    endtask

    initial begin
        bit found;
        rst_n = 0; in_valid = 0; sa_ready = 0;

        repeat (3) step(0, 1, 1);

        // single fill of bank0, reader may enter R_RUN but sa_ready is low
        repeat (DEPTH) step(1, 1, 0);
        step(1, 0, 0);
        check_val("fill_full", bank_full, 2'b01);

        // drain bank0 continuously
        ov_cnt = 0; fd_cnt = 0;
        repeat (52) step(1, 0, 1);
        check_val("drain_valid_cnt", ov_cnt, DEPTH * MODS);
        check_val("drain_frame_cnt", fd_cnt, 1);
        check_val("drain_full", bank_full, 2'b00);

        // continuous ping-pong
        repeat (200) step(1, 1, 1);

        // sa_ready toggling with random input
        for (int i = 0; i < 120; i++) step(1, 1'($urandom_range(0, 1)), 1'(i % 2 == 0));

        // reset exactly at read issue 20
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (m_run && m_idx == 20) found = 1;
            else step(1, 1'($urandom_range(0, 1)), 1);
        end
        check_val("reach_issue20", found, 1);
        step(0, 1, 1);
        step(1, 1, 0);
        check_val("post_rst_full", bank_full, 2'b00);
        check_val("post_rst_valid", out_valid, 0);
        repeat (DEPTH) step(1, 1, 0);

        // both banks full with in_valid held, then drain
        repeat (30) step(1, 1, 0);
        check_val("both_full", bank_full, 2'b11);
        repeat (120) step(1, 1, 1);

        // fully random traffic with rare resets
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) != 0));
        step(1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
